// File: rtl/ptos_lane_ser.sv
// ptos_lane_ser: parallel-to-serial converter for one PCIe PHY lane.
// Accepts DATA_W-bit symbols over valid/ready, buffers one symbol in a hold
// register and shifts symbols out MSB first on the bit-rate clock. When no
// data is buffered the COM idle symbol is sent; after reset an IDLE_PRE-long
// idle preamble is sent before in_ready may assert.
// Optional feature macro: PTOS_SKP_EN (periodic SKP symbol insertion every
// SKP_INTERVAL symbols). With the macro undefined no SKP logic exists.

module ptos_lane_ser #(
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM     = 8'hBC,
  parameter int                IDLE_PRE     = 4,
  parameter int                SKP_INTERVAL = 16,
  parameter logic [DATA_W-1:0] SKP_SYM      = 8'h1C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_s,
  output logic              out_k,
  output logic              sym_start
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PRE_W = $clog2(IDLE_PRE + 1);

  // ST_ALIGN is the single cycle after reset where the first boundary is
  // forced; afterwards boundaries come from the bit counter.
  typedef enum logic {
    ST_ALIGN,
    ST_RUN
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic [PRE_W-1:0]  pre_cnt;
  logic              pre_done;

  logic              boundary;
  logic              load_hold;
  logic              load_idle;
  logic [DATA_W-1:0] load_sym;
  logic              load_k;
  logic              accept;
  logic              hold_full_next;
  logic              pre_hit;

`ifdef PTOS_SKP_EN
  localparam int SKP_W = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;

  logic [SKP_W-1:0] skp_cnt;
  logic             skp_due;

  assign skp_due = (skp_cnt == SKP_W'(SKP_INTERVAL - 1));

  // Count symbol loads; wrap when a SKP is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      skp_cnt <= '0;
    end else if (boundary) begin
      skp_cnt <= skp_due ? '0 : skp_cnt + SKP_W'(1);
    end
  end
`else
  localparam int unused_skp_cfg = SKP_INTERVAL + int'(SKP_SYM[0]);
`endif

  // State register: the first clock out of reset is always a symbol boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_ALIGN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave alignment after exactly one clock and stay running.
  always_comb begin
    state_next = state;
    case (state)
      ST_ALIGN: state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_ALIGN;
    endcase
  end

  // Boundary detection and selection of the symbol loaded at a boundary.
  always_comb begin
    boundary  = (state == ST_ALIGN) || (bit_cnt == CNT_W'(DATA_W - 1));
    load_hold = 1'b0;
    load_idle = 1'b0;
    load_sym  = IDLE_SYM;
    load_k    = 1'b1;
    if (boundary) begin
      if (hold_full) begin
        load_hold = 1'b1;
        load_sym  = hold_data;
        load_k    = 1'b0;
      end else begin
        load_idle = 1'b1;
      end
`ifdef PTOS_SKP_EN
      if (skp_due) begin
        load_hold = 1'b0;
        load_idle = 1'b0;
        load_sym  = SKP_SYM;
        load_k    = 1'b1;
      end
`endif
    end
  end

  assign accept         = in_valid && in_ready;
  assign hold_full_next = accept | (hold_full & ~load_hold);
  assign pre_hit        = load_idle && !pre_done && (pre_cnt == PRE_W'(IDLE_PRE - 1));

  // Serializer: load a fresh symbol at a boundary, otherwise shift left.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      out_s     <= 1'b0;
      out_k     <= 1'b0;
      sym_start <= 1'b0;
    end else if (boundary) begin
      shift_reg <= {load_sym[DATA_W-2:0], 1'b0};
      bit_cnt   <= '0;
      out_s     <= load_sym[DATA_W-1];
      out_k     <= load_k;
      sym_start <= 1'b1;
    end else begin
      shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt + CNT_W'(1);
      out_s     <= shift_reg[DATA_W-1];
      sym_start <= 1'b0;
    end
  end

  // Hold register and handshake; ready drops on the accepting edge so the
  // single-entry buffer can never be overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= in_data;
      end
      hold_full <= hold_full_next;
      in_ready  <= pre_done && !hold_full_next;
    end
  end

  // Alignment preamble: count idle loads until IDLE_PRE have been sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt  <= '0;
      pre_done <= 1'b0;
    end else begin
      if (load_idle && !pre_done) begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      if (pre_hit) begin
        pre_done <= 1'b1;
      end
    end
  end

endmodule
